// File: rtl/snn_aer_pkg.sv
// snn_aer_pkg: definitions shared by the AER spike encoder and its FIFO.
//   state_e    - encoder FSM state (IDLE=0, SEND=1)
//   addr_width - event address width for an M-wide spike vector, never below 1
package snn_aer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    function automatic int addr_width(input int m);
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/spike_fifo.sv
// spike_fifo: snapshot FIFO for the AER encoder.
// Ports:
//   clk, reset         - clock, asynchronous active-low reset
//   push, push_data    - enqueue request and data (ignored when full)
//   pop                - dequeue request (ignored when empty)
//   head               - data at the read pointer (valid when !empty)
//   full, empty, count - occupancy status, all derived from the registered count
module spike_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage needs no reset: pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder: converts per-timestep spike vectors into a stream of
// address-event (AER) words, one per set bit, lowest index first.
// Ports:
//   clk, reset                      - clock, asynchronous active-low reset
//   enable                          - gates capture and starting a new snapshot
//   capture, spikes_in[M]           - timestep strobe and the spike vector it samples
//   aer_valid/aer_ready             - event handshake
//   aer_addr[AW], aer_last          - neuron index, final event of a snapshot
//   overflow, overflow_clr          - sticky dropped-snapshot flag and its clear
//   busy                            - snapshots pending or an event stream in progress
module spike_aer_encoder
    import snn_aer_pkg::*;
#(
    parameter int M     = 2,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      capture,
    input  logic [M-1:0]              spikes_in,
    output logic                      aer_valid,
    input  logic                      aer_ready,
    output logic [addr_width(M)-1:0]  aer_addr,
    output logic                      aer_last,
    output logic                      overflow,
    input  logic                      overflow_clr,
    output logic                      busy
);

    localparam int AW = addr_width(M);
    localparam int CW = $clog2(DEPTH + 1);

    state_e          state_q;
    logic [M-1:0]    work_q;
    logic            valid_q, last_q, overflow_q, overflow_d;
    logic [AW-1:0]   addr_q;

    logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [M-1:0]    fifo_head;
    logic [CW-1:0]   fifo_count;

    logic            snap_offer, start;
    logic [M-1:0]    work_clr, sel_vec;
    logic [AW-1:0]   lsb_idx;
    logic            sel_onehot;

    // A non-empty, enabled snapshot is either stored or counted as dropped.
    assign snap_offer = capture && enable && (spikes_in != '0);
    assign fifo_push  = snap_offer && (fifo_count < CW'(DEPTH));
    assign start      = (state_q == IDLE) && enable && !fifo_empty;
    assign fifo_pop   = start;

    spike_fifo #(.WIDTH(M), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (spikes_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Work register with its lowest set bit cleared (the event being accepted).
    assign work_clr = work_q & (work_q - M'(1));

    // One priority encoder serves both cases: the snapshot about to be loaded
    // (IDLE) and the remainder after the current event retires (SEND).
    assign sel_vec    = (state_q == IDLE) ? fifo_head : work_clr;
    assign sel_onehot = (sel_vec != '0) && ((sel_vec & (sel_vec - M'(1))) == '0);

    always_comb begin
        lsb_idx = '0;
        for (int i = M - 1; i >= 0; i--) begin
            if (sel_vec[i]) lsb_idx = AW'(i);
        end
    end

    // Outputs are registered and computed from the next work value, so the
    // first event appears the edge after the snapshot is popped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SEND;
                        work_q  <= fifo_head;
                        valid_q <= 1'b1;
                        addr_q  <= lsb_idx;
                        last_q  <= sel_onehot;
                    end
                end
                SEND: begin
                    if (valid_q && aer_ready) begin
                        work_q <= work_clr;
                        if (work_clr == '0) begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            addr_q  <= '0;
                            last_q  <= 1'b0;
                        end else begin
                            addr_q <= lsb_idx;
                            last_q <= sel_onehot;
                        end
                    end
                end
            endcase
        end
    end

    // Set wins over clear when both happen in one cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (overflow_clr)              overflow_d = 1'b0;
        if (snap_offer && fifo_full)   overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) overflow_q <= 1'b0;
        else        overflow_q <= overflow_d;
    end

    assign aer_valid = valid_q;
    assign aer_addr  = addr_q;
    assign aer_last  = last_q;
    assign overflow  = overflow_q;
    assign busy      = !fifo_empty || (state_q == SEND);

endmodule

// File: tb/tb_spike_aer_encoder.sv
module tb_spike_aer_encoder;

    localparam int M     = 4;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          reset, enable, capture, aer_ready, overflow_clr;
    logic [M-1:0]  spikes_in;
    logic          aer_valid, aer_last, overflow, busy;
    logic [AW-1:0] aer_addr;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          last;
    } ev_t;

    typedef struct {
        logic [M-1:0]         sp;
        logic                 en;
        int                   n;
        logic [3:0][AW-1:0]   a;
    } vec_t;

    ev_t  sb[$];
    vec_t tv[8];

    always #5 clk = ~clk;

    spike_aer_encoder #(.M(M), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .capture      (capture),
        .spikes_in    (spikes_in),
        .aer_valid    (aer_valid),
        .aer_ready    (aer_ready),
        .aer_addr     (aer_addr),
        .aer_last     (aer_last),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .busy         (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every accepted event is compared against the scoreboard head.
    always @(negedge clk) begin : monitor
        ev_t e;
        if (aer_valid && aer_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got addr %0d last %0d, expected none", aer_addr, aer_last);
            end else begin
                e = sb.pop_front();
                chk("event_addr", 32'(aer_addr), 32'(e.addr));
                chk("event_last", 32'(aer_last), 32'(e.last));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture_vec(input logic [M-1:0] v, input logic en);
        spikes_in = v;
        enable    = en;
        capture   = 1'b1;
        tick();
        capture   = 1'b0;
        spikes_in = '0;
        enable    = 1'b1;
    endtask

    task automatic expect_ev(input logic [AW-1:0] addr, input logic last);
        ev_t e;
        e.addr = addr;
        e.last = last;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        while ((sb.size() != 0 || busy) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, "_no_timeout"}, 32'(cyc < 200), 32'd1);
        chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; enable = 1'b0; capture = 1'b0; spikes_in = '0;
        aer_ready = 1'b1; overflow_clr = 1'b0;

        tv[0] = '{sp: 4'b1011, en: 1'b1, n: 3, a: 8'b00_11_01_00};
        tv[1] = '{sp: 4'b0100, en: 1'b1, n: 1, a: 8'b00_00_00_10};
        tv[2] = '{sp: 4'b1111, en: 1'b1, n: 4, a: 8'b11_10_01_00};
        tv[3] = '{sp: 4'b1000, en: 1'b1, n: 1, a: 8'b00_00_00_11};
        tv[4] = '{sp: 4'b0000, en: 1'b1, n: 0, a: 8'b00_00_00_00};
        tv[5] = '{sp: 4'b0110, en: 1'b0, n: 0, a: 8'b00_00_00_00};
        tv[6] = '{sp: 4'b0101, en: 1'b1, n: 2, a: 8'b00_00_10_00};
        tv[7] = '{sp: 4'b1110, en: 1'b1, n: 3, a: 8'b00_11_10_01};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(aer_valid), 0);
        chk("rst_addr", 32'(aer_addr), 0);
        chk("rst_last", 32'(aer_last), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b1;
        enable = 1'b1;
        tick();

        // First-event latency: capture at E0, valid visible after E1
        expect_ev(2'd0, 1'b0); expect_ev(2'd1, 1'b0); expect_ev(2'd3, 1'b1);
        capture_vec(4'b1011, 1'b1);
        @(negedge clk);
        chk("lat_valid_after_e0", 32'(aer_valid), 0);
        @(negedge clk);
        chk("lat_valid_after_e1", 32'(aer_valid), 1);
        chk("lat_addr_after_e1", 32'(aer_addr), 0);
        drain("lat");

        // Table of single snapshots with aer_ready held high
        for (int i = 0; i < 8; i++) begin
            if (tv[i].en) begin
                for (int k = 0; k < tv[i].n; k++)
                    expect_ev(tv[i].a[k], 1'(k == tv[i].n - 1));
            end
            capture_vec(tv[i].sp, tv[i].en);
            drain($sformatf("vec%0d", i));
            repeat (3) @(negedge clk);
            chk($sformatf("vec%0d_busy", i), 32'(busy), 0);
            chk($sformatf("vec%0d_overflow", i), 32'(overflow), 0);
        end

        // Backpressure: event held stable for 5 stalled cycles
        tick();
        aer_ready = 1'b0;
        expect_ev(2'd2, 1'b1);
        capture_vec(4'b0100, 1'b1);
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_valid", 32'(aer_valid), 1);
            chk("stall_addr", 32'(aer_addr), 2);
            chk("stall_last", 32'(aer_last), 1);
        end
        @(posedge clk);
        #1;
        aer_ready = 1'b1;
        drain("stall");

        // Overflow: six back-to-back captures with the sink stalled.
        // One goes to the work register, four fill the FIFO, the sixth drops.
        tick();
        aer_ready = 1'b0;
        for (int k = 0; k < 5; k++) expect_ev(2'd0, 1'b1);
        spikes_in = 4'b0001;
        capture = 1'b1;
        repeat (6) tick();
        capture = 1'b0;
        spikes_in = '0;
        @(negedge clk);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_busy", 32'(busy), 1);
        tick();
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        @(negedge clk);
        chk("ovf_clr", 32'(overflow), 0);
        // Set beats clear in the same cycle
        tick();
        spikes_in = 4'b0001; capture = 1'b1; overflow_clr = 1'b1;
        tick();
        capture = 1'b0; spikes_in = '0; overflow_clr = 1'b0;
        @(negedge clk);
        chk("ovf_set_priority", 32'(overflow), 1);
        tick();
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        // Zero snapshot, or enable low, while full does not flag
        capture_vec(4'b0000, 1'b1);
        @(negedge clk);
        chk("ovf_zero_full", 32'(overflow), 0);
        tick();
        capture_vec(4'b0001, 1'b0);
        @(negedge clk);
        chk("ovf_disabled_full", 32'(overflow), 0);
        tick();
        aer_ready = 1'b1;
        drain("ovf");

        // Enable falling mid-stream does not abort the snapshot; captures
        // while disabled are ignored.
        tick();
        expect_ev(2'd0, 1'b0); expect_ev(2'd1, 1'b0); expect_ev(2'd2, 1'b0); expect_ev(2'd3, 1'b1);
        capture_vec(4'b1111, 1'b1);
        tick();
        enable = 1'b0;
        spikes_in = 4'b0001; capture = 1'b1;
        tick();
        capture = 1'b0; spikes_in = '0;
        drain("en_fall");
        repeat (3) @(negedge clk);
        chk("en_fall_busy", 32'(busy), 0);
        tick();
        enable = 1'b1;

        // Reset after the first of three events
        expect_ev(2'd0, 1'b0);
        capture_vec(4'b0111, 1'b1);
        @(posedge clk);          // E1: first event valid
        @(posedge clk);          // E2: first event accepted
        #1;
        reset = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(aer_valid), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_first_seen", 32'(sb.size()), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_valid", 32'(aer_valid), 0);
        chk("post_rst_busy", 32'(busy), 0);
        tick();
        expect_ev(2'd1, 1'b1);
        capture_vec(4'b0010, 1'b1);
        drain("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
